// File: rtl/data_memory_pipelined.sv
// Byte-addressed data memory with configurable read latency and a busy/valid handshake.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_pipelined #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            store_signal,
    input  logic                  load_unsigned,
    output logic [31:0]           read_data,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  align_error
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } state_t;

    state_t state, next_state;
    logic [2:0] cnt, next_cnt;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] index;
    logic [1:0]       offset;
    logic [31:0]      mem_word;
    logic             misaligned;
    logic             unused_addr_bits;

    logic        write_en, accept, deliver_now, deliver_cap, misaligned_hit;
    logic [3:0]  byte_en;
    logic [31:0] store_word;

    logic [31:0] cap_word;
    logic [1:0]  cap_size;
    logic [1:0]  cap_off;
    logic        cap_uns;

    assign index            = mem_address[IDX_W+1:2];
    assign offset           = mem_address[1:0];
    assign mem_word         = mem[index];
    assign busy             = (state == READ_WAIT);
    assign unused_addr_bits = ^mem_address[ADDR_WIDTH-1:IDX_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        case (store_signal)
            2'b10:   misaligned = 1'b0;
            2'b01:   misaligned = offset[0];
            default: misaligned = (offset != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b10:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Lane enables and replicated data; misaligned offsets truncate naturally here.
    always_comb begin
        case (store_signal)
            2'b10: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                store_word = {2{write_data[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = write_data;
            end
        endcase
    end

    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        write_en       = 1'b0;
        accept         = 1'b0;
        deliver_now    = 1'b0;
        deliver_cap    = 1'b0;
        misaligned_hit = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    if (misaligned) begin
                        misaligned_hit = 1'b1;
                    end else if (mem_write) begin
                        write_en = ~reset;
                    end else begin
                        accept = 1'b1;
                        if (READ_LATENCY == 1) begin
                            deliver_now = 1'b1;
                        end else begin
                            next_state = READ_WAIT;
                            next_cnt   = 3'(READ_LATENCY - 1);
                        end
                    end
                end
            end
            READ_WAIT: begin
                if (cnt == 3'd1) begin
                    deliver_cap = 1'b1;
                    next_state  = IDLE;
                end else begin
                    next_cnt = cnt - 3'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            read_data   <= 32'd0;
            read_valid  <= 1'b0;
            align_error <= 1'b0;
            cap_word    <= 32'd0;
            cap_size    <= 2'd0;
            cap_off     <= 2'd0;
            cap_uns     <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            read_valid  <= deliver_now | deliver_cap;
            align_error <= misaligned_hit;
            if (accept) begin
                cap_word <= mem_word;
                cap_size <= store_signal;
                cap_off  <= offset;
                cap_uns  <= load_unsigned;
            end
            if (deliver_now)
                read_data <= extract(mem_word, store_signal, offset, load_unsigned);
            else if (deliver_cap)
                read_data <= extract(cap_word, cap_size, cap_off, cap_uns);
        end
    end

    // Array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i])
                    mem[index][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Self-checking bench: three instances (latency 1, 3, 4) against a byte-array reference model.
module tb_data_memory_pipelined;

    localparam int DEPTH = 16;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [2:0]  rd = '0;
    logic [2:0]  wr = '0;
    logic [2:0]  rst = '0;

    logic [31:0] rdata [3];
    logic [2:0]  rvalid;
    logic [2:0]  busy;
    logic [2:0]  aerr;

    int checks = 0;
    int errors = 0;
    int lat_of [3] = '{1, 3, 4};

    logic [7:0] mb [0:2][0:NBYTES-1];

    always #5 clk = ~clk;

    data_memory_pipelined #(.DEPTH(DEPTH), .READ_LATENCY(1), .ADDR_WIDTH(32)) d1 (
        .clk(clk), .reset(rst[0]), .mem_address(addr), .write_data(wdata),
        .mem_read(rd[0]), .mem_write(wr[0]), .store_signal(size), .load_unsigned(uns),
        .read_data(rdata[0]), .read_valid(rvalid[0]), .busy(busy[0]), .align_error(aerr[0]));

    data_memory_pipelined #(.DEPTH(DEPTH), .READ_LATENCY(3), .ADDR_WIDTH(32)) d3 (
        .clk(clk), .reset(rst[1]), .mem_address(addr), .write_data(wdata),
        .mem_read(rd[1]), .mem_write(wr[1]), .store_signal(size), .load_unsigned(uns),
        .read_data(rdata[1]), .read_valid(rvalid[1]), .busy(busy[1]), .align_error(aerr[1]));

    data_memory_pipelined #(.DEPTH(DEPTH), .READ_LATENCY(4), .ADDR_WIDTH(32)) d4 (
        .clk(clk), .reset(rst[2]), .mem_address(addr), .write_data(wdata),
        .mem_read(rd[2]), .mem_write(wr[2]), .store_signal(size), .load_unsigned(uns),
        .read_data(rdata[2]), .read_valid(rvalid[2]), .busy(busy[2]), .align_error(aerr[2]));

    function automatic int nbytes_of(input logic [1:0] s);
        return (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_rejects(input logic [31:0] a, input logic [1:0] s);
`ifdef DMEM_ALIGN_CHECK_EN
        return (a % nbytes_of(s)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_store(input int k, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] s);
        int n = nbytes_of(s);
        int base = int'(a % NBYTES);
        if (model_rejects(a, s)) return;
        base = base - (base % n);
        for (int i = 0; i < n; i++) mb[k][base + i] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [31:0] a,
                                               input logic [1:0] s, input logic u);
        int n = nbytes_of(s);
        int base = int'(a % NBYTES);
        logic [31:0] v = 32'd0;
        base = base - (base % n);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[k][base + i];
        if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_store(input logic [2:0] mask, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        addr = a; wdata = d; size = s; wr = mask;
        @(negedge clk);
        wr = '0;
        for (int k = 0; k < 3; k++) if (mask[k]) model_store(k, a, d, s);
    endtask

    // Issues one read, waits (bounded) for read_valid, reports latency and handshake sanity.
    task automatic do_load(input int k, input logic [31:0] a, input logic [1:0] s, input logic u,
                           output logic [31:0] got, output int lat, output bit hs_ok);
        @(negedge clk);
        addr = a; size = s; uns = u; rd[k] = 1'b1;
        @(negedge clk);
        rd[k] = 1'b0;
        lat = 0;
        hs_ok = 1'b1;
        while (rvalid[k] !== 1'b1 && lat < 12) begin
            if (busy[k] !== 1'b1) hs_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy[k] !== 1'b0) hs_ok = 1'b0;
        got = rdata[k];
        @(negedge clk);
        if (rvalid[k] !== 1'b0) hs_ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 3'b111;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({rdata[k], rvalid[k], busy[k], aerr[k]} !== 35'd0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got data=%h valid=%b busy=%b aerr=%b, need all 0",
                         k, rdata[k], rvalid[k], busy[k], aerr[k]);
            end
        end
        rst = 3'b000;
        for (int w = 0; w < DEPTH; w++) do_store(3'b111, 32'(w * 4), $urandom, 2'b00);
    endtask

    task automatic test_word_byte;
        logic [31:0] got;
        int lat;
        bit ok;
        do_store(3'b001, 32'd4, 32'hFDFF_FFFF, 2'b00);
        do_load(0, 32'd4, 2'b00, 1'b0, got, lat, ok);
        checks++;
        if (got !== 32'hFDFF_FFFF || lat != 0 || !ok) begin
            errors++;
            $display("FAIL word_load: got %h lat %0d hs %b, need FDFFFFFF lat 0 hs 1", got, lat, ok);
        end
        do_store(3'b001, 32'd5, 32'h0000_0080, 2'b10);
        do_load(0, 32'd5, 2'b10, 1'b0, got, lat, ok);
        checks++;
        if (got !== 32'hFFFF_FF80 || !ok) begin
            errors++;
            $display("FAIL byte_signed: got %h, need FFFFFF80", got);
        end
        do_load(0, 32'd5, 2'b10, 1'b1, got, lat, ok);
        checks++;
        if (got !== 32'h0000_0080 || !ok) begin
            errors++;
            $display("FAIL byte_unsigned: got %h, need 00000080", got);
        end
        do_load(0, 32'd4, 2'b00, 1'b0, got, lat, ok);
        checks++;
        if (got !== 32'hFDFF_80FF || !ok) begin
            errors++;
            $display("FAIL word_after_byte: got %h, need FDFF80FF", got);
        end
    endtask

    task automatic test_latency;
        logic [31:0] exp_a;
        bit extra;
        exp_a = model_load(1, 32'd12, 2'b00, 1'b0);
        @(negedge clk);
        addr = 32'd12; size = 2'b00; uns = 1'b0; rd[1] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b1 || rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL lat3_cycle1: busy %b valid %b, need 1 0", busy[1], rvalid[1]);
        end
        addr = 32'd20; rd[1] = 1'b1;
        @(negedge clk);
        rd[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b1 || rvalid[1] !== 1'b0) begin
            errors++;
            $display("FAIL lat3_cycle2: busy %b valid %b, need 1 0", busy[1], rvalid[1]);
        end
        @(negedge clk);
        checks++;
        if (rvalid[1] !== 1'b1 || busy[1] !== 1'b0 || rdata[1] !== exp_a) begin
            errors++;
            $display("FAIL lat3_deliver: valid %b busy %b data %h, need 1 0 %h",
                     rvalid[1], busy[1], rdata[1], exp_a);
        end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rvalid[1] !== 1'b0 || busy[1] !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL lat3_ignored_read: extra valid/busy seen %b, need 0", extra);
        end
    endtask

    task automatic test_misaligned_half;
        logic [31:0] got, exp;
        int lat;
        bit ok;
        logic exp_aerr;
        exp_aerr = model_rejects(32'd1, 2'b01);
        @(negedge clk);
        addr = 32'd1; wdata = 32'hFFFF_1234; size = 2'b01; wr[0] = 1'b1;
        @(negedge clk);
        wr[0] = 1'b0;
        model_store(0, 32'd1, 32'hFFFF_1234, 2'b01);
        checks++;
        if (aerr[0] !== exp_aerr) begin
            errors++;
            $display("FAIL align_error_pulse: got %b, need %b", aerr[0], exp_aerr);
        end
        exp = model_load(0, 32'd0, 2'b00, 1'b0);
        do_load(0, 32'd0, 2'b00, 1'b0, got, lat, ok);
        checks++;
        if (got !== exp || !ok || (!exp_aerr && got[15:0] !== 16'h1234)) begin
            errors++;
            $display("FAIL misaligned_half_word0: got %h, need %h", got, exp);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [31:0] got, exp;
        int lat;
        bit ok, seen;
        @(negedge clk);
        addr = 32'd16; size = 2'b00; rd[2] = 1'b1;
        @(negedge clk);
        rd[2] = 1'b0; rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        checks++;
        if (rvalid[2] !== 1'b0 || busy[2] !== 1'b0 || rdata[2] !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_read: valid %b busy %b data %h, need 0 0 0",
                     rvalid[2], busy[2], rdata[2]);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid[2] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL aborted_read_delivered: valid seen %b, need 0", seen);
        end
        exp = model_load(2, 32'd16, 2'b00, 1'b0);
        do_load(2, 32'd16, 2'b00, 1'b0, got, lat, ok);
        checks++;
        if (got !== exp || lat != 3 || !ok) begin
            errors++;
            $display("FAIL mem_after_reset: got %h lat %0d hs %b, need %h lat 3 hs 1", got, lat, ok, exp);
        end
    endtask

    task automatic test_rw_conflict;
        logic [31:0] got;
        int lat;
        bit ok;
        @(negedge clk);
        addr = 32'd8; wdata = 32'hA5A5_A5A5; size = 2'b00; rd[0] = 1'b1; wr[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b0;
        model_store(0, 32'd8, 32'hA5A5_A5A5, 2'b00);
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rw_conflict_valid: got %b, need 0", rvalid[0]);
        end
        do_load(0, 32'd8, 2'b00, 1'b0, got, lat, ok);
        checks++;
        if (got !== 32'hA5A5_A5A5 || !ok) begin
            errors++;
            $display("FAIL rw_conflict_data: got %h, need A5A5A5A5", got);
        end
        do_load(0, 32'(8 + NBYTES), 2'b00, 1'b0, got, lat, ok);
        checks++;
        if (got !== 32'hA5A5_A5A5 || !ok) begin
            errors++;
            $display("FAIL address_alias: got %h, need A5A5A5A5", got);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp [8];
        int bad = 0;
        for (int i = 0; i < 8; i++) exp[i] = model_load(0, 32'(i * 4 + 1), 2'b10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0 && (rvalid[0] !== 1'b1 || rdata[0] !== exp[i-1])) bad++;
            addr = 32'(i * 4 + 1); size = 2'b10; uns = 1'b0; rd[0] = 1'b1;
        end
        @(negedge clk);
        rd[0] = 1'b0;
        if (rvalid[0] !== 1'b1 || rdata[0] !== exp[7]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_to_back: %0d bad deliveries, need 0", bad);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, got, exp;
        logic [1:0] s;
        logic u;
        int lat;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            for (int it = 0; it < 60; it++) begin
                a = $urandom_range(0, 255);
                s = 2'($urandom_range(0, 3));
                u = 1'($urandom_range(0, 1));
                if (model_rejects(a, s)) a = a - (a % nbytes_of(s));
                if ($urandom_range(0, 1) == 0) begin
                    do_store(3'(1 << k), a, $urandom, s);
                end else begin
                    exp = model_load(k, a, s, u);
                    do_load(k, a, s, u, got, lat, ok);
                    checks++;
                    if (got !== exp || lat != lat_of[k] - 1 || !ok) begin
                        errors++;
                        $display("FAIL random_load inst%0d a=%h s=%0d u=%b: got %h lat %0d hs %b, need %h lat %0d",
                                 k, a, s, u, got, lat, ok, exp, lat_of[k] - 1);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_byte();
        test_latency();
        test_misaligned_half();
        test_reset_mid_read();
        test_rw_conflict();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
